// File: rtl/hash_pad_buf.sv
// Message block buffer for MD/SHA-style hashing: packs big-endian input words into
// 512- or 1024-bit blocks and appends the 0x80 pad byte and bit-length trailer.
module hash_pad_buf #(
   parameter int DW    = 32,
   parameter int CNT_W = 61
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       start,
   input  logic                       blk_1024,
   input  logic [DW-1:0]              wr_d,
   input  logic [$clog2(DW/8):0]      wr_nb,
   input  logic                       wr_en,
   input  logic                       wr_last,
   output logic                       wr_rdy,
   output logic [1023:0]              blk_o,
   output logic                       blk_vld,
   input  logic                       blk_rdy,
   output logic                       blk_final,
   output logic                       idle
);

   localparam int unsigned NB = DW / 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RECV,
      S_EMIT
   } state_t;

   state_t                  state_q, state_d;
   logic                    mode_q, mode_d;
   logic [127:0][7:0]       buf_q, buf_d;
   logic [7:0]              ptr_q, ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    final_q, final_d;
   logic                    len_pend_q, len_pend_d;
   logic                    pad_pend_q, pad_pend_d;

   logic [7:0]              p;
   logic [7:0]              bb;
   logic [7:0]              lb;

   // Element 127 of the packed buffer is byte 0 of the block, so blk_o is buf_q as-is.
   function automatic logic [127:0][7:0] put_len(input logic [127:0][7:0] b,
                                                 input logic m,
                                                 input logic [CNT_W-1:0] c);
      logic [127:0][7:0] r;
      logic [127:0]      len;
      int unsigned       blen;
      int unsigned       llen;
      r    = b;
      len  = 128'({c, 3'b000});
      blen = m ? 32'd128 : 32'd64;
      llen = m ? 32'd16 : 32'd8;
      for (int unsigned j = 0; j < 16; j++) begin
         if (j < llen) r[7'(128 - blen + j)] = len[8*j +: 8];
      end
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      buf_d      = buf_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      final_d    = final_q;
      len_pend_d = len_pend_q;
      pad_pend_d = pad_pend_q;
      bb         = mode_q ? 8'd128 : 8'd64;
      lb         = mode_q ? 8'd16 : 8'd8;
      p          = ptr_q + 8'(wr_nb);

      if (clr) begin
         state_d    = S_IDLE;
         mode_d     = 1'b0;
         buf_d      = '0;
         ptr_d      = '0;
         cnt_d      = '0;
         final_d    = 1'b0;
         len_pend_d = 1'b0;
         pad_pend_d = 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_d    = S_RECV;
                  mode_d     = blk_1024;
                  buf_d      = '0;
                  ptr_d      = '0;
                  cnt_d      = '0;
                  final_d    = 1'b0;
                  len_pend_d = 1'b0;
                  pad_pend_d = 1'b0;
               end
            end

            S_RECV: begin
               if (wr_en) begin
                  for (int unsigned i = 0; i < NB; i++) begin
                     if (i < 32'(wr_nb) && (32'(ptr_q) + i) < 32'(bb))
                        buf_d[7'(127 - (32'(ptr_q) + i))] = wr_d[DW-1-8*i -: 8];
                  end
                  cnt_d = cnt_q + CNT_W'(wr_nb);
                  ptr_d = p;
                  if (!wr_last) begin
                     if (p >= bb) begin
                        state_d    = S_EMIT;
                        final_d    = 1'b0;
                        len_pend_d = 1'b0;
                        pad_pend_d = 1'b0;
                     end
                  end else begin
                     state_d = S_EMIT;
                     if (p < bb) begin
                        buf_d[7'(8'd127 - p)] = 8'h80;
                        // Trailer fits only if the pad byte leaves LB free bytes.
                        if (9'(p) + 9'd1 + 9'(lb) <= 9'(bb)) begin
                           buf_d      = put_len(buf_d, mode_q, cnt_d);
                           final_d    = 1'b1;
                           len_pend_d = 1'b0;
                        end else begin
                           final_d    = 1'b0;
                           len_pend_d = 1'b1;
                        end
                        pad_pend_d = 1'b0;
                     end else begin
                        final_d    = 1'b0;
                        pad_pend_d = 1'b1;
                        len_pend_d = 1'b1;
                     end
                  end
               end
            end

            S_EMIT: begin
               if (blk_rdy) begin
                  if (final_q) begin
                     state_d = S_IDLE;
                     buf_d   = '0;
                     ptr_d   = '0;
                     final_d = 1'b0;
                  end else if (len_pend_q) begin
                     buf_d = '0;
                     if (pad_pend_q) buf_d[127] = 8'h80;
                     buf_d      = put_len(buf_d, mode_q, cnt_q);
                     final_d    = 1'b1;
                     len_pend_d = 1'b0;
                     pad_pend_d = 1'b0;
                  end else begin
                     state_d = S_RECV;
                     buf_d   = '0;
                     ptr_d   = '0;
                  end
               end
            end

            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         buf_q      <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         final_q    <= 1'b0;
         len_pend_q <= 1'b0;
         pad_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         buf_q      <= buf_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         final_q    <= final_d;
         len_pend_q <= len_pend_d;
         pad_pend_q <= pad_pend_d;
      end
   end

   assign wr_rdy    = (state_q == S_RECV);
   assign blk_vld   = (state_q == S_EMIT);
   assign idle      = (state_q == S_IDLE);
   assign blk_final = final_q;
   assign blk_o     = buf_q;

endmodule

// File: tb/tb_hash_pad_buf.sv
// Directed bench for hash_pad_buf: expected blocks are queued by the stimulus and
// checked by an independent monitor at each blk_vld & blk_rdy handshake.
module tb_hash_pad_buf;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clr = 1'b0;
   logic          start = 1'b0;
   logic          blk_1024 = 1'b0;
   logic [31:0]   wr_d = '0;
   logic [2:0]    wr_nb = '0;
   logic          wr_en = 1'b0;
   logic          wr_last = 1'b0;
   logic          wr_rdy;
   logic [1023:0] blk_o;
   logic          blk_vld;
   logic          blk_rdy = 1'b0;
   logic          blk_final;
   logic          idle;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [1023:0] blk;
      logic          fin;
   } exp_t;

   exp_t sbq[$];

   hash_pad_buf #(.DW(32), .CNT_W(61)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .blk_1024(blk_1024),
      .wr_d(wr_d), .wr_nb(wr_nb), .wr_en(wr_en), .wr_last(wr_last), .wr_rdy(wr_rdy),
      .blk_o(blk_o), .blk_vld(blk_vld), .blk_rdy(blk_rdy), .blk_final(blk_final),
      .idle(idle)
   );

   always #5 clk = ~clk;

   function automatic logic [1023:0] setb(input logic [1023:0] e, input int k,
                                          input logic [7:0] v);
      e[1023-8*k -: 8] = v;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_blk(input string nm, input logic [1023:0] got,
                          input logic [1023:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         for (int k = 0; k < 128; k++) begin
            if (got[1023-8*k -: 8] !== exp[1023-8*k -: 8]) begin
               $display("FAIL %s: byte %0d got %02h expected %02h", nm, k,
                        got[1023-8*k -: 8], exp[1023-8*k -: 8]);
               break;
            end
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && !clr && blk_vld && blk_rdy) begin
         if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_block: got final=%0b expected no block", blk_final);
         end else begin
            e = sbq.pop_front();
            chk_blk("blk_o", blk_o, e.blk);
            chk("blk_final", 64'(blk_final), 64'(e.fin));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic m);
      start = 1'b1;
      blk_1024 = m;
      tick();
      start = 1'b0;
   endtask

   task automatic wr(input logic [31:0] d, input logic [2:0] nb, input logic last);
      int n = 0;
      while (!wr_rdy && n < 50) begin
         tick();
         n++;
      end
      if (!wr_rdy) begin
         tests++;
         fails++;
         $display("FAIL wr_timeout: got wr_rdy=0 expected 1");
         return;
      end
      wr_d = d;
      wr_nb = nb;
      wr_last = last;
      wr_en = 1'b1;
      tick();
      wr_en = 1'b0;
      wr_last = 1'b0;
   endtask

   task automatic take;
      int n = 0;
      while (!blk_vld && n < 50) begin
         tick();
         n++;
      end
      if (!blk_vld) begin
         tests++;
         fails++;
         $display("FAIL blk_timeout: got blk_vld=0 expected 1");
         return;
      end
      blk_rdy = 1'b1;
      tick();
      blk_rdy = 1'b0;
   endtask

   function automatic logic [31:0] seq_word(input int w);
      logic [31:0] r;
      for (int b = 0; b < 4; b++) r[31-8*b -: 8] = 8'(4*w + b + 1);
      return r;
   endfunction

   task automatic push(input logic [1023:0] b, input logic f);
      exp_t e;
      e.blk = b;
      e.fin = f;
      sbq.push_back(e);
   endtask

   task automatic abc_case(input logic m, input string tag);
      logic [1023:0] e;
      e = '0;
      e = setb(e, 0, 8'h61);
      e = setb(e, 1, 8'h62);
      e = setb(e, 2, 8'h63);
      e = setb(e, 3, 8'h80);
      e = setb(e, m ? 127 : 63, 8'h18);
      push(e, 1'b1);
      do_start(m);
      wr(32'h6162_6300, 3'd3, 1'b1);
      chk({tag, "_latency_vld"}, 64'(blk_vld), 64'd1);
      chk({tag, "_wr_rdy_emit"}, 64'(wr_rdy), 64'd0);
      take();
      chk({tag, "_idle_after"}, 64'(idle), 64'd1);
   endtask

   task automatic reset_outputs(input string tag);
      chk({tag, "_idle"}, 64'(idle), 64'd1);
      chk({tag, "_wr_rdy"}, 64'(wr_rdy), 64'd0);
      chk({tag, "_blk_vld"}, 64'(blk_vld), 64'd0);
      chk({tag, "_blk_final"}, 64'(blk_final), 64'd0);
      chk_blk({tag, "_blk_o"}, blk_o, '0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [1023:0] e1, e2;

      rst_n = 1'b0;
      tick();
      tick();
      reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      abc_case(1'b0, "abc512");
      abc_case(1'b1, "abc1024");

      // empty message in 1024 mode
      e1 = '0;
      e1 = setb(e1, 0, 8'h80);
      push(e1, 1'b1);
      do_start(1'b1);
      wr(32'h0, 3'd0, 1'b1);
      take();

      // 56 bytes: pad fits, length spills into a second block
      e1 = '0;
      for (int k = 0; k < 56; k++) e1 = setb(e1, k, 8'(k + 1));
      e1 = setb(e1, 56, 8'h80);
      e2 = '0;
      e2 = setb(e2, 62, 8'h01);
      e2 = setb(e2, 63, 8'hC0);
      push(e1, 1'b0);
      push(e2, 1'b1);
      do_start(1'b0);
      for (int w = 0; w < 14; w++) wr(seq_word(w), 3'd4, (w == 13));
      take();
      take();

      // 64 bytes: pad and length both land in the second block
      e1 = '0;
      for (int k = 0; k < 64; k++) e1 = setb(e1, k, 8'(k + 1));
      e2 = '0;
      e2 = setb(e2, 0, 8'h80);
      e2 = setb(e2, 62, 8'h02);
      push(e1, 1'b0);
      push(e2, 1'b1);
      do_start(1'b0);
      for (int w = 0; w < 16; w++) wr(seq_word(w), 3'd4, (w == 15));
      take();
      take();

      // back-pressure in EMIT with stray writes; length proves count untouched
      do_start(1'b0);
      for (int w = 0; w < 16; w++) wr(seq_word(w), 3'd4, 1'b0);
      for (int c = 0; c < 5; c++) begin
         chk("stall_vld", 64'(blk_vld), 64'd1);
         chk("stall_wr_rdy", 64'(wr_rdy), 64'd0);
         chk_blk("stall_blk_o", blk_o, e1);
         wr_d = 32'hDEAD_BEEF;
         wr_nb = 3'd4;
         wr_en = 1'b1;
         tick();
         wr_en = 1'b0;
      end
      push(e1, 1'b0);
      take();
      push(e2, 1'b1);
      wr(32'h0, 3'd0, 1'b1);
      take();

      // clr colliding with blk_rdy mid-message
      do_start(1'b0);
      for (int w = 0; w < 16; w++) wr(seq_word(w), 3'd4, 1'b0);
      clr = 1'b1;
      blk_rdy = 1'b1;
      tick();
      clr = 1'b0;
      blk_rdy = 1'b0;
      reset_outputs("clr");
      abc_case(1'b0, "abc_after_clr");

      // async reset mid-message drops the partial block
      do_start(1'b0);
      wr(seq_word(0), 3'd4, 1'b0);
      #2;
      rst_n = 1'b0;
      #2;
      reset_outputs("midrst");
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      chk("midrst_no_vld", 64'(blk_vld), 64'd0);

      tick();
      chk("sb_empty", 64'(sbq.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
